// File: rtl/conv_out_writer.sv
// Output-side writer for the convolution engine: accumulates partial sums per filter
// window, queues finished sums in a FIFO and acknowledges each element with write_done.
// Optional macro OUT_RELU_EN clamps negative window sums to zero on push.
module conv_out_writer #(
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 20,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              conv_done,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic              last_elem,
    output logic              write_done,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [CNT_W-1:0]  out_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_ACK,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               last_q, last_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic [ACC_W-1:0]   mem_q [DEPTH];
    logic [ACC_W-1:0]   mem_d [DEPTH];

    logic               push;
    logic               pop;
    logic [ACC_W-1:0]   psum_ext;
    logic [ACC_W-1:0]   push_word;

    assign psum_ext = {{(ACC_W-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};

`ifdef OUT_RELU_EN
    assign push_word = acc_q[ACC_W-1] ? '0 : acc_q;
`else
    assign push_word = acc_q;
`endif

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(DEPTH));
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign out_count  = out_count_q;
    assign write_done = (state_q == S_ACK);
    assign pop        = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        last_d      = last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        mem_d       = mem_q;
        push        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (conv_done) begin
                    acc_d   = acc_q + psum_ext;
                    last_d  = last_elem;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!last_q) begin
                    state_d = S_ACK;
                end else if (!fifo_full || pop) begin
                    // a same-cycle pop frees the slot, so a full FIFO need not stall
                    push        = 1'b1;
                    acc_d       = '0;
                    out_count_d = out_count_q + CNT_W'(1);
                    state_d     = S_ACK;
                end
            end
            S_ACK:   state_d = S_HOLD;
            S_HOLD: begin
                if (!conv_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // start discards everything, including a push or pop decided above
        if (start) begin
            state_d     = S_IDLE;
            acc_d       = '0;
            last_d      = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            out_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            last_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_count_q <= '0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            last_q      <= last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
            mem_q       <= mem_d;
        end
    end

endmodule
